// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: word size, canonical NOP, fetch FSM states and
// the {pc, instr} entry buffered between instruction memory and decode.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both for the request-PC queue and the instruction
// buffer; flush empties it in one cycle and takes priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC generation, credit-limited in-order imem requests,
// response buffering and the IF/ID register with stall, flush and redirect.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_id,
    input  logic        flush_id,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_instr_q, id_instr_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_pc_plus4_q, id_pc_plus4_d;

    logic          ibuf_push, ibuf_pop, ibuf_flush, ibuf_empty;
    fetch_entry_t  ibuf_rdata;
    logic [CW-1:0] ibuf_count;
    logic          pcq_push, pcq_pop, pcq_flush, pcq_empty;
    logic [31:0]   pcq_rdata;
    logic [CW-1:0] pcq_count;

    logic          credit_ok, req_fire, rsp_ok, do_load;
    logic [CW:0]   inflight;
    fetch_entry_t  rsp_entry, load_entry;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
        .clk(clk), .rst(rst), .flush_i(ibuf_flush), .push_i(ibuf_push),
        .wdata_i(rsp_entry), .pop_i(ibuf_pop), .rdata_o(ibuf_rdata),
        .count_o(ibuf_count), .empty_o(ibuf_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pcq (
        .clk(clk), .rst(rst), .flush_i(pcq_flush), .push_i(pcq_push),
        .wdata_i(pc_q), .pop_i(pcq_pop), .rdata_o(pcq_rdata),
        .count_o(pcq_count), .empty_o(pcq_empty)
    );

    // Buffered words plus words still in flight never exceed the buffer size.
    assign inflight       = {1'b0, outstanding_q} + {1'b0, ibuf_count};
    assign credit_ok      = inflight < (CW + 1)'(FIFO_DEPTH);
    assign imem_req_valid = !rst && (state_q == RUN) && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_entry      = '{pc: pcq_rdata, instr: imem_rsp_data};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
        drop_d        = drop_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        ibuf_push     = 1'b0;
        ibuf_pop      = 1'b0;
        ibuf_flush    = 1'b0;
        pcq_push      = 1'b0;
        pcq_pop       = 1'b0;
        pcq_flush     = 1'b0;
        do_load       = 1'b0;
        load_entry    = ibuf_rdata;

        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    // Everything still owed by memory, including a request
                    // accepted this cycle, belongs to the wrong path.
                    pc_d       = align_word(redirect_pc);
                    drop_d     = outstanding_d;
                    ibuf_flush = 1'b1;
                    pcq_flush  = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = (outstanding_d != '0) ? DRAIN : RUN;
                end else begin
                    if (req_fire) begin
                        pc_d     = pc_q + 32'd4;
                        pcq_push = 1'b1;
                    end
                    pcq_pop = rsp_ok;
                    if (flush_id) begin
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                        ibuf_push  = rsp_ok;
                    end else if (!id_valid_q || !stall_id) begin
                        if (!ibuf_empty) begin
                            do_load    = 1'b1;
                            load_entry = ibuf_rdata;
                            ibuf_pop   = 1'b1;
                            ibuf_push  = rsp_ok;
                        end else if (rsp_ok) begin
                            do_load    = 1'b1;
                            load_entry = rsp_entry;
                        end else begin
                            id_valid_d = 1'b0;
                            id_instr_d = NOP_INSTR;
                        end
                    end else begin
                        ibuf_push = rsp_ok;
                    end
                end
            end
            DRAIN: begin
                if (rsp_ok) drop_d = drop_q - CW'(1);
                if (redirect_valid) begin
                    pc_d       = align_word(redirect_pc);
                    ibuf_flush = 1'b1;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
                if (drop_d == '0) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (do_load) begin
            id_valid_d    = 1'b1;
            id_instr_d    = load_entry.instr;
            id_pc_d       = load_entry.pc;
            id_pc_plus4_d = load_entry.pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

    rsp_protocol: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));

    pcq_tracking: assert property (@(posedge clk) disable iff (rst)
        (state_q == RUN) |-> ((pcq_count == outstanding_q) && !(rsp_ok && pcq_empty)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard of expected fetch PCs is consumed by
// a monitor each time IF/ID presents a new instruction; memory echoes addr as data.
module tb_fetch_stage;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        flush_id;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    memReq_t     memQ[$];
    logic [31:0] expQ[$];
    int          memLatency = 1;
    int          grantsLeft = 0;
    int          cycle      = 0;
    int          checkCount = 0;
    int          passCount  = 0;
    logic        heldPrev   = 1'b0;
    logic [31:0] lastPc     = '0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_id(stall_id), .flush_id(flush_id),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    endtask

    // Memory model: requests are sampled mid-cycle, responses driven just after the edge.
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            memQ.push_back('{addr: imem_req_addr, due: cycle + memLatency});
            grantsLeft--;
        end
        @(posedge clk);
        #1;
        cycle++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (memQ.size() > 0 && memQ[0].due == cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memQ[0].addr;
            void'(memQ.pop_front());
        end
        imem_req_ready = (grantsLeft > 0);
    endtask

    task automatic applyStimulus(input int grants);
        grantsLeft     = grants;
        imem_req_ready = (grants > 0);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || memQ.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, 32'(n < 60), 32'd1);
        repeat (2) tick();
    endtask

    // Monitor: a newly loaded IF/ID entry pops the scoreboard; a held one must not change.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (rst) begin
            heldPrev = 1'b0;
        end else begin
            if (id_valid) begin
                if (heldPrev) begin
                    checkOutput("hold_pc", id_pc, lastPc);
                end else if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_instr: got pc %h, expected none", id_pc);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("id_pc", id_pc, exp);
                    checkOutput("id_instr", id_instr, exp);
                    checkOutput("id_pc_plus4", id_pc_plus4, exp + 32'd4);
                    lastPc = exp;
                end
            end else begin
                checkOutput("nop_when_invalid", id_instr, NOP_INSTR);
            end
            heldPrev = id_valid && stall_id && !flush_id && !redirect_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] t1[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] t2[6] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
        logic [31:0] t5[3] = '{32'h204, 32'h208, 32'h20C};
        logic [31:0] t6[3] = '{32'h0, 32'h4, 32'h8};

        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; stall_id = 1'b0; flush_id = 1'b0;
        tick();
        tick();
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_id_instr", id_instr, NOP_INSTR);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Streaming with 1-cycle memory
        rst = 1'b0;
        cycle = 0;
        foreach (t1[i]) expQ.push_back(t1[i]);
        applyStimulus(4);
        #1;
        checkOutput("c0_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("c0_req_addr", imem_req_addr, 32'h0);
        tick();
        checkOutput("c1_id_valid", 32'(id_valid), 32'd0);
        tick();
        checkOutput("c2_id_valid", 32'(id_valid), 32'd1);
        for (int i = 3; i <= 5; i++) begin
            tick();
            checkOutput("stream_id_valid", 32'(id_valid), 32'd1);
        end
        tick();
        checkOutput("c6_id_valid", 32'(id_valid), 32'd0);
        checkOutput("c6_req_addr", imem_req_addr, 32'h10);
        waitDrain("stream");

        // Decode stall for three cycles while streaming
        foreach (t2[i]) expQ.push_back(t2[i]);
        applyStimulus(6);
        tick();
        tick();
        tick();
        stall_id = 1'b1;
        tick();
        tick();
        checkOutput("stall_credit_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_id_pc", id_pc, 32'h14);
        checkOutput("stall_id_valid", 32'(id_valid), 32'd1);
        tick();
        stall_id = 1'b0;
        waitDrain("stall");

        // Redirect with two requests outstanding on 3-cycle memory
        memLatency = 3;
        applyStimulus(2);
        tick();
        tick();
        checkOutput("two_outstanding_req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checkOutput("redir_id_valid", 32'(id_valid), 32'd0);
        checkOutput("redir_id_instr", id_instr, NOP_INSTR);
        checkOutput("drain_req_valid", 32'(imem_req_valid), 32'd0);
        expQ.push_back(32'h100);
        expQ.push_back(32'h104);
        applyStimulus(2);
        tick();
        checkOutput("drain2_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("post_drain_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("post_drain_req_addr", imem_req_addr, 32'h100);
        waitDrain("redirect");

        // Misaligned redirect target
        memLatency = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        checkOutput("align_req_addr", imem_req_addr, 32'h200);
        checkOutput("align_req_valid", 32'(imem_req_valid), 32'd1);
        expQ.push_back(32'h200);
        applyStimulus(1);
        waitDrain("align");

        // flush_id together with stall_id while the FIFO holds two words
        foreach (t5[i]) expQ.push_back(t5[i]);
        applyStimulus(3);
        tick();
        tick();
        stall_id = 1'b1;
        tick();
        tick();
        checkOutput("preflush_id_pc", id_pc, 32'h204);
        flush_id = 1'b1;
        tick();
        flush_id = 1'b0;
        stall_id = 1'b0;
        checkOutput("flush_id_valid", 32'(id_valid), 32'd0);
        checkOutput("flush_id_instr", id_instr, NOP_INSTR);
        waitDrain("flush");

        // Reset mid-stream with a full FIFO
        expQ.push_back(32'h210);
        stall_id = 1'b1;
        applyStimulus(8);
        repeat (4) tick();
        checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("full_id_pc", id_pc, 32'h210);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_id = 1'b0;
        memQ.delete();
        applyStimulus(0);
        #1;
        checkOutput("midrst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("midrst_req_addr", imem_req_addr, 32'h0);
        checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd1);
        foreach (t6[i]) expQ.push_back(t6[i]);
        applyStimulus(3);
        waitDrain("restart");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
